// File: rtl/ft601_wr_ctrl.sv
// ft601_wr_ctrl: FT601 245-sync FIFO transmit engine.
// Pops 36-bit words (data + byte enables) from an FWFT FIFO and writes them to
// the FT601 in WR_N-low bursts. A word refused by the chip (TXE_N high while
// WR_N is low) is held on the bus and replayed later, so nothing is lost or
// duplicated.
// Optional build macro FT601_WR_STATS_EN adds the words_sent / stall_cycles
// counters.
//
// WR_N idle time: the final GAP cycle also evaluates the IDLE start condition.
// This keeps WR_N high for exactly GAP_CYCLES cycles between back-to-back
// bursts. With GAP_CYCLES=0 the burst returns straight to IDLE, which costs one
// WR_N-high cycle.
module ft601_wr_ctrl #(
  parameter int MAX_BURST  = 1024,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [35:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        ft_txe_n,
  output logic        ft_wr_n,
  output logic [31:0] ft_data,
  output logic [3:0]  ft_be,
  output logic        ft_data_oe,
  output logic        busy,
  output logic        burst_done
`ifdef FT601_WR_STATS_EN
  ,
  output logic [31:0] words_sent,
  output logic [31:0] stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_wr_n;
  logic             r_oe;
  logic [31:0]      r_data;
  logic [3:0]       r_be;
  logic             r_pend;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_done;

  state_t           w_state_nxt;
  logic             w_wr_n_nxt;
  logic             w_oe_nxt;
  logic [31:0]      w_data_nxt;
  logic [3:0]       w_be_nxt;
  logic             w_pend_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             w_done_nxt;

  logic w_acc;
  logic w_start;
  logic w_burst_end;

  // The chip takes a word on any edge where our strobe is low and it has space.
  assign w_acc = !r_wr_n && !ft_txe_n;
  // No pop may escape while reset is held: the FIFO would lose the word.
  assign w_start = !reset && ce && !ft_txe_n && (r_pend || s_valid);
  // After an accepted word, stop at the length limit, on empty upstream, or on disable.
  assign w_burst_end = (r_burst_cnt == CNT_MAX) || !s_valid || !ce;

  // Next-state, pop strobe and next register values.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_n_nxt  = r_wr_n;
    w_oe_nxt    = r_oe;
    w_data_nxt  = r_data;
    w_be_nxt    = r_be;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_burst_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_done_nxt  = 1'b0;
    s_ready     = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (r_state == S_GAP && r_gap_cnt != GAP_LAST) begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end else if (w_start) begin
          w_state_nxt = S_BURST;
          w_wr_n_nxt  = 1'b0;
          w_oe_nxt    = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_gap_nxt   = '0;
          if (r_pend) begin
            // Held word is still on ft_data/ft_be; just present it again.
            w_pend_nxt = 1'b0;
          end else begin
            s_ready    = 1'b1;
            w_data_nxt = s_data[31:0];
            w_be_nxt   = s_data[35:32];
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end
      end
      S_BURST: begin
        if (w_acc && !w_burst_end) begin
          s_ready    = 1'b1;
          w_data_nxt = s_data[31:0];
          w_be_nxt   = s_data[35:32];
          w_cnt_nxt  = r_burst_cnt + CNT_W'(1);
        end else begin
          // Either the last word went out, or the chip refused it and we hold it.
          if (!w_acc) w_pend_nxt = 1'b1;
          w_wr_n_nxt  = 1'b1;
          w_oe_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_gap_nxt   = '0;
          w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_wr_n_nxt  = 1'b1;
        w_oe_nxt    = 1'b0;
      end
    endcase
  end

  // State and bus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_data      <= '0;
      r_be        <= '0;
      r_pend      <= 1'b0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_n      <= w_wr_n_nxt;
      r_oe        <= w_oe_nxt;
      r_data      <= w_data_nxt;
      r_be        <= w_be_nxt;
      r_pend      <= w_pend_nxt;
      r_burst_cnt <= w_cnt_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign ft_wr_n    = r_wr_n;
  assign ft_data    = r_data;
  assign ft_be      = r_be;
  assign ft_data_oe = r_oe;
  assign burst_done = r_done;
  assign busy       = (r_state != S_IDLE) || r_pend;

`ifdef FT601_WR_STATS_EN
  logic [31:0] r_words_sent;
  logic [31:0] r_stall_cycles;
  logic        w_stall;

  assign w_stall = ft_txe_n && ((r_state == S_BURST) || (r_state == S_IDLE && r_pend));

  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_words_sent   <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_words_sent   <= r_words_sent + {31'd0, w_acc};
      r_stall_cycles <= r_stall_cycles + {31'd0, w_stall};
    end
  end

  assign words_sent   = r_words_sent;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_ft601_wr_ctrl.sv
// Bench for ft601_wr_ctrl: upstream FIFO + FT601 receiver model.
// Every word handed out by the FIFO must reach the host exactly once, in order;
// burst length, gap length, OE and burst_done follow the bus-level rules.
module tb_ft601_wr_ctrl;
  localparam int MAXB = 4;
  localparam int GAPC = 2;

  logic        clk = 1'b0;
  logic        reset, ce, s_valid, s_ready, ft_txe_n;
  logic        ft_wr_n, ft_data_oe, busy, burst_done;
  logic [35:0] s_data;
  logic [31:0] ft_data;
  logic [3:0]  ft_be;

  always #5 clk = ~clk;

  ft601_wr_ctrl #(.MAX_BURST(MAXB), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .reset(reset), .ce(ce), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n), .ft_data(ft_data),
    .ft_be(ft_be), .ft_data_oe(ft_data_oe), .busy(busy), .burst_done(burst_done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference: src holds every word ever pushed; FIFO = src[pop_idx..], host got src[..rx_idx).
  logic [35:0] src[$];
  int pop_idx = 0, rx_idx = 0;
  int txe_mode = 0, gate_pct = 100;
  bit ce_rand = 0;
  bit ref_arm = 0, ce_arm = 0;
  logic [31:0] ref_val, ce_val;
  int ce_hold = 0, cyc = 0;
  bit prev_wr_n = 1, first_burst = 1;
  int hi_run = 0, cur_len = 0, n_done = 0;
  int lens_q[$], gaps_q[$];

  task automatic push_seq(input int n, input logic [35:0] base);
    for (int i = 0; i < n; i++) src.push_back(base + 36'(i));
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) src.push_back(36'({$urandom(), $urandom()}));
  endtask

  task automatic clear_stats();
    lens_q.delete(); gaps_q.delete(); n_done = 0; first_burst = 1;
  endtask

  task automatic step();
    logic t, c, g;
    @(negedge clk);
    cyc++;
    t = 1'b0;
    if (txe_mode == 1) t = ($urandom_range(0, 3) == 0);
    else if (txe_mode == 2) t = ((cyc % 2) == 1);
    if (ref_arm && !ft_wr_n && ft_data == ref_val) begin t = 1'b1; ref_arm = 0; end
    c = 1'b1;
    if (ce_arm && !ft_wr_n && ft_data == ce_val) begin ce_arm = 0; ce_hold = 6; end
    if (ce_hold > 0) begin c = 1'b0; ce_hold--; end
    else if (ce_rand && $urandom_range(0, 15) == 0) c = 1'b0;
    g = ($urandom_range(0, 99) < gate_pct);
    ft_txe_n = t;
    ce       = c;
    s_valid  = g && (pop_idx < src.size());
    s_data   = s_valid ? src[pop_idx] : 36'({$urandom(), $urandom()});
    #1;
    chk("oe_vs_wr", 64'(ft_data_oe), 64'(!ft_wr_n));
    chk("burst_done", 64'(burst_done), 64'(!prev_wr_n && ft_wr_n));
    if (burst_done) n_done++;
    if (!ft_wr_n && prev_wr_n) begin
      if (!first_burst) begin
        chk("gap_min", 64'(hi_run >= GAPC), 64'(1));
        gaps_q.push_back(hi_run);
      end
      first_burst = 0;
      cur_len = 0;
    end
    if (ft_wr_n && !prev_wr_n) begin
      chk("burst_max", 64'(cur_len <= MAXB), 64'(1));
      lens_q.push_back(cur_len);
    end
    if (ft_wr_n) hi_run++; else hi_run = 0;
    if (!ft_wr_n) chk("busy_in_burst", 64'(busy), 64'(1));
    if (!ft_wr_n && !ft_txe_n) begin
      chk("acc_has_word", 64'(rx_idx < pop_idx), 64'(1));
      if (rx_idx < pop_idx) chk("word", 64'({ft_be, ft_data}), 64'(src[rx_idx]));
      rx_idx++;
      cur_len++;
    end
    if (s_ready) begin
      chk("pop_valid", 64'(s_valid), 64'(1));
      chk("pop_ce", 64'(ce), 64'(1));
      if (s_valid) pop_idx++;
    end
    prev_wr_n = ft_wr_n;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    txe_mode = 0; gate_pct = 100; ce_rand = 0;
    while ((rx_idx < src.size() || busy || ce_hold > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_rx", 64'(rx_idx), 64'(src.size()));
    chk("drain_pop", 64'(pop_idx), 64'(src.size()));
    chk("drain_idle", 64'(busy), 64'(0));
    chk("drain_wr_n", 64'(ft_wr_n), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_l[3];
    int n;
    reset = 1'b1; ce = 1'b0; s_valid = 1'b0; s_data = '0; ft_txe_n = 1'b1;
    #1;
    chk("rst_wr_n", 64'(ft_wr_n), 64'(1));
    chk("rst_data", 64'(ft_data), 64'(0));
    chk("rst_be", 64'(ft_be), 64'(0));
    chk("rst_oe", 64'(ft_data_oe), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(burst_done), 64'(0));
    chk("rst_ready", 64'(s_ready), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic: 10 words, bursts 4,4,2 with exactly GAPC high cycles between.
    clear_stats();
    push_seq(10, 36'h1);
    drain(200);
    exp_l = '{4, 4, 2};
    chk("basic_nbursts", 64'(lens_q.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      chk("basic_len", 64'((i < lens_q.size()) ? lens_q[i] : -1), 64'(exp_l[i]));
    chk("basic_ngaps", 64'(gaps_q.size()), 64'(2));
    for (int i = 0; i < 2; i++)
      chk("basic_gap", 64'((i < gaps_q.size()) ? gaps_q[i] : -1), 64'(GAPC));
    chk("basic_done_cnt", 64'(n_done), 64'(3));

    // Refusal: chip refuses 0x203, which must be replayed, not re-popped.
    clear_stats();
    push_seq(6, 36'h201);
    ref_val = 32'h203; ref_arm = 1;
    drain(200);
    chk("ref_used", 64'(ref_arm), 64'(0));
    chk("ref_len0", 64'((lens_q.size() > 0) ? lens_q[0] : -1), 64'(2));
    chk("ref_len1", 64'((lens_q.size() > 1) ? lens_q[1] : -1), 64'(4));
    chk("ref_done_cnt", 64'(n_done), 64'(2));

    // Empty upstream: burst ends at the last word, stays idle until refilled.
    clear_stats();
    push_seq(5, 36'h301);
    drain(200);
    chk("empty_len0", 64'((lens_q.size() > 0) ? lens_q[0] : -1), 64'(4));
    chk("empty_len1", 64'((lens_q.size() > 1) ? lens_q[1] : -1), 64'(1));
    repeat (8) begin
      step();
      chk("empty_wr_n", 64'(ft_wr_n), 64'(1));
      chk("empty_ready", 64'(s_ready), 64'(0));
    end
    push_seq(3, 36'h306);
    drain(200);

    // ce drops while word 0x402 is on the bus: that word finishes, then resume.
    clear_stats();
    push_seq(8, 36'h401);
    ce_val = 32'h402; ce_arm = 1;
    drain(300);
    chk("ce_used", 64'(ce_arm), 64'(0));
    chk("ce_len0", 64'((lens_q.size() > 0) ? lens_q[0] : -1), 64'(2));
    chk("ce_len1", 64'((lens_q.size() > 1) ? lens_q[1] : -1), 64'(4));

    // Byte enables travel with their data word.
    clear_stats();
    src.push_back(36'hE_DEADBEEF);
    src.push_back(36'h3_12345678);
    drain(100);
    chk("be_len", 64'((lens_q.size() > 0) ? lens_q[0] : -1), 64'(2));

    // TXE_N toggling every cycle.
    push_rand(40);
    txe_mode = 2; gate_pct = 100; ce_rand = 0;
    n = 0;
    while (rx_idx < src.size() && n < 1000) begin step(); n++; end
    drain(200);

    // Random TXE_N, upstream gaps and ce drops.
    push_rand(300);
    txe_mode = 1; gate_pct = 70; ce_rand = 1;
    repeat (1500) step();
    drain(3000);

    // Asynchronous reset in the middle of a burst.
    push_rand(20);
    txe_mode = 0; gate_pct = 100; ce_rand = 0;
    n = 0;
    do begin step(); n++; end while (!(!ft_wr_n && cur_len >= 2) && n < 100);
    chk("rst_in_burst", 64'(ft_wr_n), 64'(0));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr_n", 64'(ft_wr_n), 64'(1));
    chk("mid_rst_oe", 64'(ft_data_oe), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0; ce = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_rst_wr_n", 64'(ft_wr_n), 64'(1));
    chk("hold_rst_data", 64'(ft_data), 64'(0));
    // Words popped but never accepted are gone; the next FIFO word comes first.
    rx_idx = pop_idx;
    prev_wr_n = 1; hi_run = 0; cur_len = 0; first_burst = 1;
    reset = 1'b0;
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
